// File: rtl/cascade_pkg.sv
// Shared constants, feature-count table and state type for the Haar cascade sequencer.
package cascade_pkg;

  localparam int unsigned NUM_STAGES  = 22;
  localparam int unsigned TOTAL_FEATS = 2135;
  localparam int unsigned STAGE_W     = 5;
  localparam int unsigned FIDX_W      = 8;

  // Features per stage; the running sum of this table is the global feature address.
  localparam logic [FIDX_W-1:0] FEAT_COUNT [NUM_STAGES] = '{
    8'd3,   8'd16,  8'd21,  8'd39,  8'd33,  8'd44,  8'd50,  8'd51,
    8'd56,  8'd71,  8'd80,  8'd103, 8'd111, 8'd102, 8'd135, 8'd137,
    8'd140, 8'd160, 8'd177, 8'd182, 8'd211, 8'd213
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/stage_feat_count.sv
// Combinational lookup of the number of features in a cascade stage.
module stage_feat_count
  import cascade_pkg::*;
(
  input  logic [STAGE_W-1:0] stage,
  output logic [FIDX_W-1:0]  feat_count_c
);

  always_comb begin
    feat_count_c = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (stage == STAGE_W'(i)) feat_count_c = FEAT_COUNT[i];
    end
  end

endmodule

// File: rtl/cascade_sequencer.sv
// Walks one window through the Haar cascade: issues features, accumulates votes,
// checks each stage sum against its threshold and stops at the first rejection.
module cascade_sequencer #(
  parameter int unsigned VOTE_W     = 16,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned NUM_STAGES = 22,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     feat_valid,
  input  logic                     feat_ready,
  output logic [ADDR_W-1:0]        feat_addr,
  output logic [4:0]               stage_idx,
  output logic [7:0]               feat_idx,
  input  logic                     vote_valid,
  input  logic signed [VOTE_W-1:0] vote,
  input  logic signed [ACC_W-1:0]  stage_thresh,
  output logic                     done,
  output logic                     face,
  output logic [4:0]               reject_stage
);

  import cascade_pkg::*;

  seq_state_e state, state_next;
  logic busy_d, feat_valid_d, done_d;
  logic signed [ACC_W-1:0] sum;
  logic [7:0] feat_count;
  logic last_feat, stage_pass, final_stage;

  stage_feat_count u_feat_count (
    .stage        (stage_idx),
    .feat_count_c (feat_count)
  );

  assign last_feat   = (feat_idx == (feat_count - 8'd1));
  assign stage_pass  = (sum >= stage_thresh);
  assign final_stage = (stage_idx == 5'(NUM_STAGES - 1));

  // State register; control outputs are registered copies of the next-state decode.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      feat_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= busy_d;
      feat_valid <= feat_valid_d;
      done       <= done_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_ISSUE;
      ST_ISSUE: if (feat_ready) state_next = ST_WAIT;
      ST_WAIT:  if (vote_valid) state_next = last_feat ? ST_CHECK : ST_ISSUE;
      ST_CHECK: state_next = (stage_pass && !final_stage) ? ST_ISSUE : ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) state_next = ST_IDLE;
  end

  always_comb begin
    busy_d       = (state_next == ST_ISSUE) || (state_next == ST_WAIT) ||
                   (state_next == ST_CHECK);
    feat_valid_d = (state_next == ST_ISSUE);
    done_d       = (state_next == ST_DONE);
  end

  // Datapath: counters, stage sum and held result; abort freezes everything.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stage_idx    <= '0;
      feat_idx     <= '0;
      feat_addr    <= '0;
      sum          <= '0;
      face         <= 1'b0;
      reject_stage <= '0;
    end else if (!abort || (state == ST_IDLE)) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            stage_idx <= '0;
            feat_idx  <= '0;
            feat_addr <= '0;
            sum       <= '0;
          end
        end
        ST_WAIT: begin
          if (vote_valid) begin
            sum <= sum + ACC_W'(vote);
            if (!last_feat) begin
              feat_idx  <= feat_idx + 8'd1;
              feat_addr <= feat_addr + ADDR_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (!stage_pass) begin
            reject_stage <= stage_idx;
            face         <= 1'b0;
          end else if (final_stage) begin
            reject_stage <= 5'(NUM_STAGES);
            face         <= 1'b1;
          end else begin
            stage_idx <= stage_idx + 5'd1;
            feat_idx  <= '0;
            feat_addr <= feat_addr + ADDR_W'(1);
            sum       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cascade_sequencer.md
Name: cascade_sequencer

Overview:
Sequences one detection window through the 22-stage Haar cascade. For each stage it issues every feature to the feature evaluator, accumulates the signed votes, and compares the sum with the stage threshold. It exits early on the first rejecting stage. It sits between the window scanner (start/done) and the feature evaluator (request/vote handshake), and it owns the stage/feature counters that index the feature-count table.

Parameters:
VOTE_W, 16, signed vote width returned by the evaluator
ACC_W, 24, signed stage-sum accumulator width; must satisfy ACC_W >= VOTE_W + 8
NUM_STAGES, 22, cascade depth
ADDR_W, 12, global feature address width; total feature count is 2135

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: begin classifying the current window
abort  in  1  synchronous: drop the current window, return to IDLE
busy  out  1  high from the cycle after an accepted start until done
feat_valid  out  1  feature request valid
feat_ready  in  1  evaluator accepts the request
feat_addr  out  ADDR_W  global feature index (running count across all stages)
stage_idx  out  5  current stage 0..21; also addresses the external threshold ROM
feat_idx  out  8  feature index within the stage
vote_valid  in  1  evaluator vote valid
vote  in  VOTE_W  signed vote for the outstanding feature
stage_thresh  in  ACC_W  signed threshold for stage_idx; combinational from the ROM, stable while stage_idx is stable
done  out  1  one-cycle pulse: result valid
face  out  1  1 = all stages passed; held until the next start
reject_stage  out  5  stage that rejected the window; NUM_STAGES when face=1; held

Behaviour:
- Reset (async, Reset_n=0) clears all state:
  - state=IDLE; busy, feat_valid, done, face = 0.
  - stage_idx, feat_idx, feat_addr = 0.
  - accumulator = 0; reject_stage = 0.
- States:
  - IDLE: start=1 → ISSUE. Clears stage, feature, address and sum. Sets busy=1 next cycle.
  - ISSUE: feat_valid=1 with stable addr/idx outputs. On feat_valid&feat_ready → WAIT.
  - WAIT: on vote_valid, sum <= sum + sign-extended vote, then:
    - if feat_idx == FEAT_COUNT[stage]-1 → CHECK;
    - else feat_idx++, feat_addr++, → ISSUE.
  - CHECK (1 cycle): signed compare of sum >= stage_thresh.
    - False: reject_stage <= stage_idx, face <= 0 → DONE.
    - True and stage_idx == 21: face <= 1, reject_stage <= 22 → DONE.
    - True otherwise: stage_idx++, feat_idx <= 0, feat_addr++, sum <= 0 → ISSUE.
  - DONE: done=1 for exactly one cycle, busy drops in the same cycle → IDLE.
- Only one request is outstanding at a time. vote_valid is ignored outside WAIT.
- feat_ready is ignored when feat_valid=0. feat_valid never drops without a handshake, except on abort or reset.
- start is ignored unless in IDLE, including a start coincident with DONE.
- abort has priority over all transitions in every non-IDLE state:
  - next state IDLE, busy=0, feat_valid=0, no done pulse.
  - face and reject_stage retain their previous values.
- Reset mid-window: immediate return to reset values. The evaluator is expected to be reset by the same Reset_n.
- Overflow: 213 × 2^15 < 2^23, so the sum never wraps at the default widths. No saturation logic.
- Latency, zero-wait evaluator (ready=1, vote the cycle after the handshake):
  - 2 cycles per feature plus 1 CHECK per stage.
  - Full pass: 2×2135 + 22 + 1 (DONE) cycles after start.
  - Stage-0 rejection: done asserts 8 cycles after start.

Decomposition:
- Package cascade_pkg holds:
  - NUM_STAGES and TOTAL_FEATS = 2135;
  - constant array FEAT_COUNT[22] = {3,16,21,39,33,44,50,51,56,71,80,103,111,102,135,137,140,160,177,182,211,213};
  - the state enum type.
- One sub-module, stage_feat_count: a combinational lookup of FEAT_COUNT by stage, returning 8 bits. It is instantiated once in the sequencer. The stage-end compare uses its output minus 1.

Test Plan:
- Stage-0 reject: votes +10,+10,+10, stage_thresh=40 → 3 requests at addr 0,1,2; done with face=0, reject_stage=0, 8 cycles after start.
- Full pass: all votes +1, thresh = FEAT_COUNT[s] → 2135 requests with addr 0..2134 contiguous, stage_idx steps at addr 3,19,40,…; done with face=1, reject_stage=22.
- Stage-3 reject: pass stages 0-2, stage 3 votes −1 with thresh 0 → 39 stage-3 requests with first addr 40; done with reject_stage=3.
- Backpressure: feat_ready low 5 cycles, vote delayed 3 cycles → feat_valid/addr held stable; spurious vote_valid in ISSUE ignored; sum unaffected.
- Abort in WAIT of stage 2 → next cycle IDLE, busy=0, no done; subsequent start restarts at addr 0 with sum 0.
- Reset_n low mid-stage 5, async, between clock edges → outputs at reset values immediately; start during busy and during the DONE cycle is ignored.
